// File: rtl/mdr_sequencer.sv
// Request/response front end for the multiply/divide/sqrt unit.
// Screens bad requests, strobes flush/start, waits with timeout.
module mdr_sequencer #(
  parameter int WORD_LENGTH    = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [WORD_LENGTH-1:0] req_x,
  input  logic [WORD_LENGTH-1:0] req_y,
  output logic [WORD_LENGTH-1:0] mdr_dataX,
  output logic [WORD_LENGTH-1:0] mdr_dataY,
  output logic [1:0]             mdr_op,
  output logic                   mdr_start,
  output logic                   mdr_flush,
  input  logic                   mdr_ready,
  input  logic [WORD_LENGTH-1:0] mdr_result,
  input  logic [WORD_LENGTH-1:0] mdr_remainder,
  input  logic                   mdr_sign,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WORD_LENGTH-1:0] rsp_result,
  output logic [WORD_LENGTH-1:0] rsp_remainder,
  output logic                   rsp_sign,
  output logic [1:0]             rsp_error,
  output logic                   busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST =
    CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] E_OK  = 2'b00;
  localparam logic [1:0] E_DIV = 2'b01;
  localparam logic [1:0] E_OP  = 2'b10;
  localparam logic [1:0] E_TO  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    START,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  assign req_ready = (state == IDLE);
  assign mdr_flush = (state == FLUSH);
  assign mdr_start = (state == START);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      mdr_dataX     <= '0;
      mdr_dataY     <= '0;
      mdr_op        <= '0;
      rsp_result    <= '0;
      rsp_remainder <= '0;
      rsp_sign      <= 1'b0;
      rsp_error     <= E_OK;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            mdr_dataX <= req_x;
            mdr_dataY <= req_y;
            mdr_op    <= req_op;
            if (req_op == 2'b11) begin
              rsp_error     <= E_OP;
              rsp_result    <= '0;
              rsp_remainder <= '0;
              rsp_sign      <= 1'b0;
              state         <= RESP;
            end else if (req_op == 2'b01 &&
                         req_y == '0) begin
              rsp_error     <= E_DIV;
              rsp_result    <= '0;
              rsp_remainder <= '0;
              rsp_sign      <= 1'b0;
              state         <= RESP;
            end else begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: state <= START;
        START: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          // ready on the last timeout cycle still wins
          if (mdr_ready) begin
            rsp_result    <= mdr_result;
            rsp_remainder <= mdr_remainder;
            rsp_sign      <= mdr_sign;
            rsp_error     <= E_OK;
            state         <= RESP;
          end else if (cnt == LAST) begin
            rsp_result    <= '0;
            rsp_remainder <= '0;
            rsp_sign      <= 1'b0;
            rsp_error     <= E_TO;
            state         <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdr_sequencer.sv
// Randomized bench for mdr_sequencer with a delay-programmable MDR stub.
// Expected responses and latencies come from the request rules directly.
module tb_mdr_sequencer;

  localparam int W  = 16;
  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, req_ready;
  logic [1:0]   req_op;
  logic [W-1:0] req_x, req_y;
  logic [W-1:0] mdr_dataX, mdr_dataY;
  logic [1:0]   mdr_op;
  logic         mdr_start, mdr_flush, mdr_ready;
  logic [W-1:0] mdr_result, mdr_remainder;
  logic         mdr_sign;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_result, rsp_remainder;
  logic         rsp_sign;
  logic [1:0]   rsp_error;
  logic         busy;

  always #5 clk = ~clk;

  mdr_sequencer #(.WORD_LENGTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_x(req_x), .req_y(req_y),
    .mdr_dataX(mdr_dataX), .mdr_dataY(mdr_dataY),
    .mdr_op(mdr_op), .mdr_start(mdr_start),
    .mdr_flush(mdr_flush), .mdr_ready(mdr_ready),
    .mdr_result(mdr_result),
    .mdr_remainder(mdr_remainder),
    .mdr_sign(mdr_sign),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result),
    .rsp_remainder(rsp_remainder),
    .rsp_sign(rsp_sign), .rsp_error(rsp_error),
    .busy(busy)
  );

  // MDR stub: ready pulses stub_d cycles after the start strobe
  int           stub_d;
  int           scnt;
  logic [W-1:0] stub_res, stub_rem, junk;
  logic         stub_sign;

  always @(posedge clk) begin
    junk <= W'($urandom);
    if (reset || mdr_flush) scnt <= 0;
    else if (mdr_start) scnt <= stub_d;
    else if (scnt > 0) scnt <= scnt - 1;
  end

  assign mdr_ready     = (scnt == 1);
  assign mdr_result    = mdr_ready ? stub_res : junk;
  assign mdr_remainder = mdr_ready ? stub_rem : ~junk;
  assign mdr_sign      = mdr_ready ? stub_sign : junk[0];

  int checks = 0;
  int passes = 0;

  logic [W-1:0] e_res, e_rem, e_x, e_y;
  logic         e_sign;
  logic [1:0]   e_err, e_op;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h want %0h",
                tag, obs, exp);
  endtask

  // Issue one request and follow it to the response
  task automatic run_req(input logic [1:0] op,
                         input logic [W-1:0] x,
                         input logic [W-1:0] y,
                         input int d,
                         input logic [W-1:0] r,
                         input logic [W-1:0] m,
                         input logic s);
    int n, lat, exp_lat, nfl, nst, fl_at, st_at;
    stub_d = d; stub_res = r;
    stub_rem = m; stub_sign = s;
    req_op = op; req_x = x; req_y = y;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("req_ready_wait", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (op == 2'b11) e_err = 2'b10;
    else if (op == 2'b01 && y == 0) e_err = 2'b01;
    else if (d < 1 || d > TO) e_err = 2'b11;
    else e_err = 2'b00;
    if (e_err == 2'b01 || e_err == 2'b10) exp_lat = 0;
    else if (e_err == 2'b11) exp_lat = 2 + TO;
    else exp_lat = 2 + d;
    e_res  = (e_err == 2'b00) ? r : '0;
    e_rem  = (e_err == 2'b00) ? m : '0;
    e_sign = (e_err == 2'b00) ? s : 1'b0;
    e_x = x; e_y = y; e_op = op;
    chk("cap_x", mdr_dataX, x);
    chk("cap_y", mdr_dataY, y);
    chk("cap_op", mdr_op, op);
    lat = 0; nfl = 0; nst = 0;
    fl_at = -1; st_at = -1;
    while (!rsp_valid && lat < 200) begin
      if (mdr_flush) begin nfl++; fl_at = lat; end
      if (mdr_start) begin nst++; st_at = lat; end
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, exp_lat);
    chk("n_flush", nfl, exp_lat == 0 ? 0 : 1);
    chk("n_start", nst, exp_lat == 0 ? 0 : 1);
    if (exp_lat != 0) begin
      chk("flush_at", fl_at, 0);
      chk("start_at", st_at, 1);
    end
    chk("rsp_error", rsp_error, e_err);
    chk("rsp_result", rsp_result, e_res);
    chk("rsp_rem", rsp_remainder, e_rem);
    chk("rsp_sign", rsp_sign, e_sign);
    chk("rsp_busy", busy, 1);
  endtask

  task automatic drain(input int hold);
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_req_rdy", req_ready, 0);
      chk("hold_rsp",
          {rsp_error, rsp_sign, rsp_result,
           rsp_remainder[12:0]},
          {e_err, e_sign, e_res, e_rem[12:0]});
      chk("hold_cap", {mdr_op, mdr_dataX, mdr_dataY},
          {e_op, e_x, e_y});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("to_idle", {busy, rsp_valid, req_ready}, 3'b001);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_x = '0; req_y = '0;
    stub_d = 0; stub_res = '0; stub_rem = '0;
    stub_sign = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl",
        {req_ready, busy, rsp_valid, mdr_start,
         mdr_flush},
        5'b10000);
    chk("rst_data",
        {mdr_dataX, mdr_dataY, mdr_op, rsp_result,
         rsp_remainder[13:0], rsp_sign, rsp_error},
        '0);
    reset = 1'b0;
    @(posedge clk); #1;

    // mult 12*5, ready five cycles after start
    run_req(2'b00, 16'd12, 16'd5, 5,
            16'd60, 16'd0, 1'b0);
    drain(1);
    // divide by zero and reserved op
    run_req(2'b01, 16'd100, 16'd0, 3,
            16'hdead, 16'hbeef, 1'b1);
    drain(0);
    run_req(2'b11, 16'd3, 16'd4, 3,
            16'hdead, 16'hbeef, 1'b1);
    chk("illegal_op_reg", mdr_op, 2'b11);
    drain(0);
    // timeout, ready on final cycle, ready just late
    run_req(2'b00, 16'd9, 16'd9, 0,
            16'd81, 16'd0, 1'b0);
    drain(0);
    run_req(2'b00, 16'd9, 16'd9, TO,
            16'd81, 16'd0, 1'b0);
    drain(0);
    run_req(2'b10, 16'd9, 16'd0, TO + 1,
            16'd3, 16'd0, 1'b0);
    drain(0);

    // backpressure with a pending request
    run_req(2'b01, 16'd23, 16'd3, 4,
            16'd7, 16'd2, 1'b0);
    req_op = 2'b00; req_x = 16'd6; req_y = 16'd7;
    req_valid = 1'b1;
    drain(10);
    run_req(2'b00, 16'd6, 16'd7, 2,
            16'd42, 16'd0, 1'b0);
    drain(0);

    // reset during WAIT
    stub_d = 0;
    req_op = 2'b00; req_x = 16'h55; req_y = 16'h66;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_ctl",
        {busy, req_ready, rsp_valid, mdr_start,
         mdr_flush},
        5'b01000);
    chk("mid_rst_data",
        {mdr_dataX, mdr_dataY, mdr_op, rsp_result,
         rsp_remainder[13:0], rsp_sign, rsp_error},
        '0);
    run_req(2'b10, 16'd49, 16'd0, 6,
            16'd7, 16'd0, 1'b0);
    drain(0);

    // randomized traffic
    for (int t = 0; t < 30; t++) begin
      logic [1:0]   op;
      logic [W-1:0] x, y, r, m;
      int           d;
      op = 2'($urandom_range(0, 3));
      x  = W'($urandom);
      y  = ($urandom_range(0, 3) == 0) ?
           '0 : W'($urandom);
      r  = W'($urandom);
      m  = W'($urandom);
      d  = ($urandom_range(0, 7) == 0) ?
           $urandom_range(TO - 1, TO + 3) :
           $urandom_range(0, 12);
      run_req(op, x, y, d, r, m, 1'($urandom));
      drain($urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mdr_sequencer.md
Name: mdr_sequencer

Overview:
- Front-end controller placed directly upstream of the multiply/divide/square-root unit (MDR).
- Accepts one operation request at a time over a valid/ready handshake and holds the operands and op code stable towards the MDR.
- Sequences the MDR's flush and start strobes, waits for its ready with a timeout, then latches result/remainder/sign into a response register that is held until the consumer takes it.
- Screens illegal op codes and divide-by-zero before the MDR is started.

Parameters:
WORD_LENGTH, 16, operand/result width; must match the MDR instance.
TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT before declaring a timeout (≥2).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_op  in  2  00 mult, 01 div, 10 sqrt, 11 reserved
req_x  in  WORD_LENGTH  operand X (multiplicand/dividend/radicand)
req_y  in  WORD_LENGTH  operand Y (multiplier/divisor)
mdr_dataX  out  WORD_LENGTH  captured X to MDR
mdr_dataY  out  WORD_LENGTH  captured Y to MDR
mdr_op  out  2  captured op to MDR
mdr_start  out  1  MDR start strobe
mdr_flush  out  1  MDR flush strobe
mdr_ready  in  1  MDR done
mdr_result  in  WORD_LENGTH  MDR result
mdr_remainder  in  WORD_LENGTH  MDR remainder
mdr_sign  in  1  MDR sign
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_result  out  WORD_LENGTH  latched result
rsp_remainder  out  WORD_LENGTH  latched remainder
rsp_sign  out  1  latched sign
rsp_error  out  2  00 ok, 01 divide-by-zero, 10 illegal op, 11 timeout
busy  out  1  high in any state other than IDLE

Behaviour:
- One clock domain. Reset is synchronous and active-high.
  - On reset: FSM goes to IDLE; wait counter = 0.
  - All outputs = 0, except req_ready = 1.
- FSM states: IDLE, FLUSH, START, WAIT, RESP. All strobes and flags are decoded from the registered state (Moore).
- IDLE:
  - req_ready = 1.
  - Request handshake = req_valid & req_ready at a rising edge. On handshake, capture req_x, req_y and req_op into the mdr_data*/mdr_op registers.
  - req_op == 11: go to RESP with rsp_error = 10.
  - req_op == 01 and req_y == 0: go to RESP with rsp_error = 01.
  - On either error path: rsp_result, rsp_remainder and rsp_sign = 0; the MDR is never strobed.
  - Otherwise go to FLUSH.
- FLUSH: mdr_flush = 1 for exactly one cycle; go to START.
- START: mdr_start = 1 for exactly one cycle; clear the wait counter; go to WAIT.
- mdr_ready is ignored in IDLE, FLUSH and START.
- WAIT:
  - The counter increments each cycle.
  - If mdr_ready = 1: latch mdr_result, mdr_remainder and mdr_sign into rsp_*; set rsp_error = 00; go to RESP.
  - Else if counter == TIMEOUT_CYCLES-1: set rsp_error = 11; set rsp_result, rsp_remainder and rsp_sign = 0; go to RESP.
  - mdr_ready arriving on the final timeout cycle counts as success (ready wins).
- RESP:
  - rsp_valid = 1 and req_ready = 0. New requests are not accepted; the sequencer does not overlap requests.
  - rsp_* are held stable until rsp_valid & rsp_ready at an edge, then go to IDLE.
  - rsp_ready is ignored outside RESP.
- mdr_dataX, mdr_dataY and mdr_op change only on a request handshake. They hold through RESP and IDLE until the next capture.
- Values are passed through unmodified: no sign or width conversion. For mult, rsp_remainder carries mdr_remainder as supplied.
- Latency, with the request handshake at edge T:
  - FLUSH occupies cycle T+1, START T+2, first WAIT cycle T+3.
  - If mdr_ready is first seen high in WAIT cycle T+3+k, rsp_valid rises at T+4+k.
  - Error path: rsp_valid rises at T+1.
  - Timeout: rsp_valid rises at T+3+TIMEOUT_CYCLES.
- Wait counter width is clog2(TIMEOUT_CYCLES). It never wraps, because the timeout compare precedes overflow.
- Reset in any state, including mid-WAIT: takes effect at that edge. Any MDR operation in flight is abandoned; the next request's FLUSH clears it.

Test Plan:
- Mult via behavioural MDR stub (ready 5 cycles after start, result 60): req op=00 x=12 y=5 at T.
  - Required: mdr_flush at T+1, mdr_start at T+2, rsp_valid at T+8.
  - Response: result=60, error=00.
- Div by zero: op=01 x=100 y=0.
  - Required: no mdr_flush or mdr_start; rsp_valid at T+1 with error=01, result=0, remainder=0.
- Illegal op: op=11 x=3 y=4.
  - Required: rsp_valid at T+1 with error=10; mdr_op register reads 11.
- Timeout: TIMEOUT_CYCLES=64, stub never asserts ready.
  - Required: exactly 64 WAIT cycles, then rsp_valid with error=11, result=0.
  - Repeat with ready on the 64th WAIT cycle: required error=00.
- Backpressure: complete a div (stub returns result 7, remainder 2), then hold rsp_ready=0 for 10 cycles while driving req_valid=1.
  - Required: rsp_* stable, req_ready=0, no new capture.
  - After rsp_ready=1: IDLE next cycle, the pending request is accepted, and its FLUSH follows.
- Reset mid-WAIT (cycle T+5): next cycle busy=0, req_ready=1, rsp_valid=0, mdr_start=0, mdr_flush=0, all data outputs 0.
  - A following sqrt request (op=10 x=49, stub returns 7) completes normally with error=00.
